// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ core: owns pc/stat and walks each instruction through its stages.
// Optional performance counters (cyc_cnt, ins_cnt) are enabled by defining Y86_SEQ_PERF_CNT_EN.
module y86_seq_ctrl #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] START_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    output logic              dmem_req,
    input  logic              dmem_ack,
    input  logic              dmem_error,
    input  logic              cnd,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valP,
    input  logic [ADDR_W-1:0] valM,
    output logic [ADDR_W-1:0] pc,
    output logic              en_decode,
    output logic              en_execute,
    output logic              en_wb,
    output logic [3:0]        stat,
`ifdef Y86_SEQ_PERF_CNT_EN
    output logic              busy,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ins_cnt
`else
    output logic              busy
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT
    } state_t;

    typedef enum logic [3:0] {
        STAT_AOK = 4'd1,
        STAT_HLT = 4'd2,
        STAT_ADR = 4'd3,
        STAT_INS = 4'd4
    } stat_t;

    if (ADDR_W < 1 || CNT_W < 1) begin : gParamCheck
        $error("y86_seq_ctrl: ADDR_W and CNT_W must be at least 1");
    end

    state_t            state, stateNext;
    stat_t             statR, statNext;
    logic [ADDR_W-1:0] pcNext;
    logic [3:0]        icodeR;
    logic [ADDR_W-1:0] valCR, valPR, valMR;
    logic              cndR;
    logic              fetchAck, memAck, memOp;

    assign stat = statR;

    // An ack only counts while our own registered request is up.
    always_comb begin
        fetchAck = (state == FETCH) && imem_req && imem_ack;
        memAck   = (state == MEMORY) && dmem_req && dmem_ack;
        memOp    = icodeR inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        busy     = (state != IDLE) && (state != HALT);
    end

    always_comb begin
        stateNext  = state;
        statNext   = statR;
        pcNext     = pc;
        en_decode  = 1'b0;
        en_execute = 1'b0;
        en_wb      = 1'b0;
        case (state)
            IDLE: if (start) stateNext = FETCH;
            FETCH: begin
                if (fetchAck) begin
                    if (imem_error) begin
                        statNext  = STAT_ADR;
                        stateNext = HALT;
                    end else if (!instr_valid) begin
                        statNext  = STAT_INS;
                        stateNext = HALT;
                    end else if (icode == 4'h0) begin
                        statNext  = STAT_HLT;
                        pcNext    = valP;
                        stateNext = HALT;
                    end else begin
                        stateNext = DECODE;
                    end
                end
            end
            DECODE: begin
                en_decode = 1'b1;
                stateNext = EXECUTE;
            end
            EXECUTE: begin
                en_execute = 1'b1;
                stateNext  = memOp ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                if (memAck) begin
                    if (dmem_error) begin
                        statNext  = STAT_ADR;
                        stateNext = HALT;
                    end else begin
                        stateNext = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                en_wb     = 1'b1;
                stateNext = PCUPD;
            end
            PCUPD: begin
                stateNext = FETCH;
                case (icodeR)
                    4'h8:    pcNext = valCR;
                    4'h7:    pcNext = cndR ? valCR : valPR;
                    4'h9:    pcNext = valMR;
                    default: pcNext = valPR;
                endcase
            end
            HALT: begin
                if (start) begin
                    pcNext    = START_PC;
                    statNext  = STAT_AOK;
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // dmem_req is armed from EXECUTE so a zero-wait access spends a single cycle in MEMORY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            statR    <= STAT_AOK;
            pc       <= START_PC;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
        end else begin
            state    <= stateNext;
            statR    <= statNext;
            pc       <= pcNext;
            imem_req <= (state == FETCH) && !fetchAck;
            dmem_req <= ((state == EXECUTE) && memOp) || ((state == MEMORY) && !memAck);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icodeR <= '0;
            valCR  <= '0;
            valPR  <= '0;
            valMR  <= '0;
            cndR   <= 1'b0;
        end else begin
            if (fetchAck) begin
                icodeR <= icode;
                valCR  <= valC;
                valPR  <= valP;
            end
            if (state == EXECUTE) cndR <= cnd;
            if (memAck) valMR <= valM;
        end
    end

`ifdef Y86_SEQ_PERF_CNT_EN
    logic startOk;
    assign startOk = start && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (startOk) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (state == PCUPD && ins_cnt != '1) ins_cnt <= ins_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Bench for y86_seq_ctrl: directed scenarios plus randomized instructions with random memory wait states.
module tb_y86_seq_ctrl;
    localparam int unsigned ADDR_W   = 64;
    localparam logic [63:0] START_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        imem_req, imem_ack, instr_valid, imem_error;
    logic [3:0]  icode;
    logic        dmem_req, dmem_ack, dmem_error, cnd;
    logic [63:0] valC, valP, valM, pc;
    logic        en_decode, en_execute, en_wb, busy;
    logic [3:0]  stat;
`ifdef Y86_SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt, ins_cnt;
`endif

    always #5 clk = ~clk;

    y86_seq_ctrl #(.ADDR_W(ADDR_W), .START_PC(START_PC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .cnd(cnd), .valC(valC), .valP(valP), .valM(valM), .pc(pc),
        .en_decode(en_decode), .en_execute(en_execute), .en_wb(en_wb),
        .stat(stat),
`ifdef Y86_SEQ_PERF_CNT_EN
        .busy(busy), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
`else
        .busy(busy)
`endif
    );

    typedef struct {
        logic [3:0]  icode;
        bit          valid, ierr, derr, cnd;
        logic [63:0] valC, valP, valM;
        int          iwait, dwait;
    } instr_t;

    int          nChecks = 0;
    int          nPass   = 0;
    int          idx     = 0;
    int          c0;
    logic [63:0] curPc;
    bit          hlt, abrt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t mk(input logic [3:0] ic, input bit v, input bit ie, input bit de,
                                  input bit cd, input logic [63:0] c, input logic [63:0] p,
                                  input logic [63:0] m, input int iw, input int dw);
        instr_t r;
        r.icode = ic; r.valid = v; r.ierr = ie; r.derr = de; r.cnd = cd;
        r.valC = c; r.valP = p; r.valM = m; r.iwait = iw; r.dwait = dw;
        return r;
    endfunction

    function automatic instr_t rnd();
        instr_t r;
        int     sel;
        sel     = int'($urandom_range(0, 99));
        r.ierr  = (sel < 4);
        r.valid = !(sel >= 4 && sel < 8);
        r.icode = (sel >= 8 && sel < 13) ? 4'h0 : 4'($urandom_range(1, 11));
        r.derr  = ($urandom_range(0, 14) == 0);
        r.cnd   = 1'($urandom);
        r.valC  = {$urandom, $urandom};
        r.valP  = {$urandom, $urandom};
        r.valM  = {$urandom, $urandom};
        r.iwait = int'($urandom_range(0, 3));
        r.dwait = int'($urandom_range(0, 3));
        return r;
    endfunction

    // Runs one instruction starting at cycle c0 relative to its FETCH entry and checks it against the model.
    task automatic runInstr(input instr_t in, input bit abortMem, output bit halted, output bit aborted);
        int fa, t, eDec, eEx, eWb, eRise, eHalt, eDreq, ePcChg;
        logic [63:0] ePc;
        logic [3:0]  eStat;
        int cyc, decC, exC, wbC, decN, exN, wbN, dreqN, riseC, haltC, pcChgC, iHigh, dHigh;
        logic prevReq;
        logic [63:0] pc0;

        fa = 1 + in.iwait;
        eDec = -1; eEx = -1; eWb = -1; eRise = -1; eHalt = -1; eDreq = 0; ePcChg = -1;
        ePc = curPc; eStat = 4'd1;
        if (in.ierr) begin
            eStat = 4'd3; eHalt = fa + 1;
        end else if (!in.valid) begin
            eStat = 4'd4; eHalt = fa + 1;
        end else if (in.icode == 4'h0) begin
            eStat = 4'd2; eHalt = fa + 1; ePc = in.valP;
            if (ePc != curPc) ePcChg = fa + 1;
        end else begin
            eDec = fa + 1; eEx = fa + 2; t = fa + 3;
            if (in.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                eDreq = in.dwait + 1;
                if (in.derr) begin
                    eStat = 4'd3; eHalt = t + in.dwait + 1;
                end else begin
                    eWb = t + in.dwait + 1;
                end
            end else begin
                eWb = t;
            end
            if (eWb >= 0) begin
                eRise = eWb + 3;
                if (in.icode == 4'h8 || (in.icode == 4'h7 && in.cnd)) ePc = in.valC;
                else if (in.icode == 4'h9) ePc = in.valM;
                else ePc = in.valP;
                if (ePc != curPc) ePcChg = eWb + 2;
            end
        end

        cyc = c0; pc0 = curPc; prevReq = imem_req;
        decC = -1; exC = -1; wbC = -1; decN = 0; exN = 0; wbN = 0; dreqN = 0;
        riseC = -1; haltC = -1; pcChgC = -1; iHigh = 0; dHigh = 0;
        halted = 1'b0; aborted = 1'b0;
        while (cyc < c0 + 60) begin
            if (en_decode)  begin decN++; decC = cyc; end
            if (en_execute) begin exN++;  exC  = cyc; end
            if (en_wb)      begin wbN++;  wbC  = cyc; end
            if (dmem_req) dreqN++;
            if (pcChgC < 0 && pc !== pc0) pcChgC = cyc;
            if (!busy) begin haltC = cyc; halted = 1'b1; break; end
            if (wbN > 0 && imem_req && !prevReq) begin riseC = cyc; break; end
            if (abortMem && dmem_req) begin aborted = 1'b1; break; end
            prevReq = imem_req;

            if (imem_req) iHigh++;
            if (imem_req && iHigh == in.iwait + 1) begin
                imem_ack = 1'b1; icode = in.icode; instr_valid = in.valid; imem_error = in.ierr;
                valC = in.valC; valP = in.valP;
            end else begin
                imem_ack = imem_req ? 1'b0 : ($urandom_range(0, 3) == 0);
                icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'($urandom);
                valC = {$urandom, $urandom}; valP = {$urandom, $urandom};
            end
            if (dmem_req) dHigh++;
            if (dmem_req && dHigh == in.dwait + 1) begin
                dmem_ack = 1'b1; dmem_error = in.derr; valM = in.valM;
            end else begin
                dmem_ack = dmem_req ? 1'b0 : ($urandom_range(0, 3) == 0);
                dmem_error = 1'($urandom); valM = {$urandom, $urandom};
            end
            cnd   = en_execute ? in.cnd : 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
        end
        start = 1'b0;
        if (aborted) return;

        check($sformatf("i%0d.dec_cycle", idx), decC, eDec);
        check($sformatf("i%0d.dec_count", idx), decN, (eDec >= 0) ? 1 : 0);
        check($sformatf("i%0d.exe_cycle", idx), exC, eEx);
        check($sformatf("i%0d.exe_count", idx), exN, (eEx >= 0) ? 1 : 0);
        check($sformatf("i%0d.wb_cycle", idx), wbC, eWb);
        check($sformatf("i%0d.wb_count", idx), wbN, (eWb >= 0) ? 1 : 0);
        check($sformatf("i%0d.dmem_req_cycles", idx), dreqN, eDreq);
        check($sformatf("i%0d.next_fetch_req", idx), riseC, eRise);
        check($sformatf("i%0d.halt_cycle", idx), haltC, eHalt);
        check($sformatf("i%0d.pc_change_cycle", idx), pcChgC, ePcChg);
        check($sformatf("i%0d.pc", idx), pc, ePc);
        check($sformatf("i%0d.stat", idx), stat, eStat);
        curPc = ePc;
        c0 = 1;
        idx++;
    endtask

    task automatic doStart();
        imem_ack = 1'b0; dmem_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = 0;
        curPc = START_PC;
    endtask

    task automatic restart(input string tag);
        doStart();
        check({tag, ".pc"}, pc, START_PC);
        check({tag, ".stat"}, stat, 4'd1);
        check({tag, ".busy"}, busy, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; icode = '0; instr_valid = 1'b0;
        imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0; cnd = 1'b0;
        valC = '0; valP = '0; valM = '0;
        repeat (3) tick();
        check("reset.pc", pc, START_PC);
        check("reset.stat", stat, 4'd1);
        check("reset.busy", busy, 1'b0);
        check("reset.imem_req", imem_req, 1'b0);
        check("reset.dmem_req", dmem_req, 1'b0);
        check("reset.strobes", {en_decode, en_execute, en_wb}, 3'b000);
        rst_n = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (2) tick();
        check("idle_ack.busy", busy, 1'b0);
        check("idle_ack.imem_req", imem_req, 1'b0);

        doStart();
        runInstr(mk(4'h1, 1, 0, 0, 0, 64'h0, 64'h0A, 64'h0, 0, 0), 0, hlt, abrt);
        runInstr(mk(4'h7, 1, 0, 0, 1, 64'h100, 64'h109, 64'h0, 0, 0), 0, hlt, abrt);
        runInstr(mk(4'h7, 1, 0, 0, 0, 64'h100, 64'h109, 64'h0, 1, 0), 0, hlt, abrt);
        runInstr(mk(4'h9, 1, 0, 0, 0, 64'h0, 64'h1234, 64'h40, 0, 3), 0, hlt, abrt);
        runInstr(mk(4'h7, 1, 0, 0, 1, 64'h20, 64'h49, 64'h0, 0, 0), 0, hlt, abrt);
        runInstr(mk(4'h0, 1, 0, 0, 0, 64'h0, 64'h21, 64'h0, 0, 0), 0, hlt, abrt);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (3) tick();
        check("halt_hold.pc", pc, 64'h21);
        check("halt_hold.stat", stat, 4'd2);
        check("halt_hold.busy", busy, 1'b0);
        check("halt_hold.imem_req", imem_req, 1'b0);
        restart("restart1");

        runInstr(mk(4'h6, 0, 1, 0, 0, 64'h0, 64'h3000, 64'h0, 2, 0), 0, hlt, abrt);
        restart("restart2");

        runInstr(mk(4'h5, 1, 0, 0, 0, 64'h0, 64'h100A, 64'h77, 0, 5), 1, hlt, abrt);
        check("abort.reached_memory", abrt, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort.dmem_req", dmem_req, 1'b0);
        check("abort.busy", busy, 1'b0);
        check("abort.pc", pc, START_PC);
        check("abort.stat", stat, 4'd1);
`ifdef Y86_SEQ_PERF_CNT_EN
        check("abort.cyc_cnt", cyc_cnt, 32'd0);
        check("abort.ins_cnt", ins_cnt, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_error = 1'b1; imem_ack = 1'b1; valM = 64'hDEAD;
        repeat (3) tick();
        check("late_ack.dmem_req", dmem_req, 1'b0);
        check("late_ack.imem_req", imem_req, 1'b0);
        check("late_ack.busy", busy, 1'b0);
        check("late_ack.stat", stat, 4'd1);
        check("late_ack.pc", pc, START_PC);

        restart("restart3");
        for (int k = 0; k < 40; k++) begin
            runInstr(rnd(), 0, hlt, abrt);
            if (hlt) restart($sformatf("rnd_restart%0d", k));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
